// File: rtl/instruction_loader.sv
// Assembles UART bytes (little-endian) into instruction words and writes them
// into the instruction memory, stopping on the halt word or a memory-full error.
module instruction_loader #(
  parameter int WORD_SIZE_IN_BYTES = 4,
  parameter int BYTE_BITS          = 8,
  parameter int MEM_SIZE_IN_WORDS  = 64,
  localparam int WORD_BITS = WORD_SIZE_IN_BYTES * BYTE_BITS,
  localparam int CNT_W     = $clog2(MEM_SIZE_IN_WORDS + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_load_start,
  input  logic [BYTE_BITS-1:0] i_rx_data,
  input  logic                 i_rx_valid,
  input  logic                 i_full_mem,
  output logic                 o_clear_mem,
  output logic                 o_write_mem,
  output logic [WORD_BITS-1:0] o_instruction,
  output logic [CNT_W-1:0]     o_word_count,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [2:0]           o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RECEIVE = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_e;

  localparam int IDX_W = (WORD_SIZE_IN_BYTES > 1) ? $clog2(WORD_SIZE_IN_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_SIZE_IN_BYTES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MEM_SIZE_IN_WORDS);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [WORD_BITS-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 clear_q, clear_d;
  logic                 write_q, write_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [WORD_BITS-1:0] word_full;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      instr_q <= '0;
      count_q <= '0;
      clear_q <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      instr_q <= instr_d;
      count_q <= count_d;
      clear_q <= clear_d;
      write_q <= write_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    instr_d   = instr_q;
    count_d   = count_q;
    clear_d   = 1'b0;
    write_d   = 1'b0;
    done_d    = done_q;
    error_d   = error_q;
    // The last byte completes the word directly from the input lane.
    word_full = shift_q;
    word_full[WORD_BITS-1 -: BYTE_BITS] = i_rx_data;

    case (state_q)
      S_CLEAR: state_d = S_RECEIVE;
      S_RECEIVE: begin
        if (i_load_start) begin
          state_d = S_CLEAR;
          clear_d = 1'b1;
          count_d = '0;
          idx_d   = '0;
          shift_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end else if (i_rx_valid) begin
          if (idx_q != LAST_IDX) begin
            shift_d[int'(idx_q)*BYTE_BITS +: BYTE_BITS] = i_rx_data;
            idx_d = idx_q + 1'b1;
          end else if (i_full_mem) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            idx_d   = '0;
          end else begin
            instr_d = word_full;
            write_d = 1'b1;
            idx_d   = '0;
            if (count_q < MAX_CNT) count_d = count_q + 1'b1;
            if (&word_full) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: begin
        if (i_load_start) begin
          state_d = S_CLEAR;
          clear_d = 1'b1;
          count_d = '0;
          idx_d   = '0;
          shift_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
    endcase

    busy_d = (state_d == S_CLEAR) || (state_d == S_RECEIVE);
  end

  assign o_clear_mem   = clear_q;
  assign o_write_mem   = write_q;
  assign o_instruction = instr_q;
  assign o_word_count  = count_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: one default-size instance plus a
// two-word instance for the memory-full case, with a write-pulse scoreboard.
module tb_instruction_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ld_a, vld_a, full_a, ld_b, vld_b, full_b;
  logic [7:0]  dat_a, dat_b;
  logic        clr_a, wr_a, busy_a, done_a, err_a;
  logic        clr_b, wr_b, busy_b, done_b, err_b;
  logic [31:0] instr_a, instr_b;
  logic [6:0]  cnt_a;
  logic [1:0]  cnt_b;
  logic [2:0]  st_a, st_b;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  instruction_loader dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_load_start(ld_a), .i_rx_data(dat_a),
    .i_rx_valid(vld_a), .i_full_mem(full_a), .o_clear_mem(clr_a),
    .o_write_mem(wr_a), .o_instruction(instr_a), .o_word_count(cnt_a),
    .o_busy(busy_a), .o_done(done_a), .o_error(err_a), .o_state(st_a)
  );

  instruction_loader #(.MEM_SIZE_IN_WORDS(2)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_load_start(ld_b), .i_rx_data(dat_b),
    .i_rx_valid(vld_b), .i_full_mem(full_b), .o_clear_mem(clr_b),
    .o_write_mem(wr_b), .o_instruction(instr_b), .o_word_count(cnt_b),
    .o_busy(busy_b), .o_done(done_b), .o_error(err_b), .o_state(st_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the next expected word.
  always @(negedge clk) begin
    if (wr_a === 1'b1) begin
      if (exp_q_a.size() == 0) check("wr_a_unexpected", {31'b0, wr_a}, 32'd0);
      else check("wr_a_word", instr_a, exp_q_a.pop_front());
    end
    if (wr_b === 1'b1) begin
      if (exp_q_b.size() == 0) check("wr_b_unexpected", {31'b0, wr_b}, 32'd0);
      else check("wr_b_word", instr_b, exp_q_b.pop_front());
    end
  end

  task automatic tick_a(input logic l, input logic v, input logic [7:0] d);
    ld_a = l; vld_a = v; dat_a = d;
    @(negedge clk);
  endtask

  task automatic tick_b(input logic l, input logic v, input logic [7:0] d);
    ld_b = l; vld_b = v; dat_b = d;
    @(negedge clk);
  endtask

  task automatic send_word_a(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tick_a(1'b0, 1'b1, w[8*i +: 8]);
    ld_a = 1'b0; vld_a = 1'b0;
  endtask

  task automatic send_word_b(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tick_b(1'b0, 1'b1, w[8*i +: 8]);
    ld_b = 1'b0; vld_b = 1'b0;
  endtask

  task automatic check_all_zero_a(input string tag);
    check({tag, "_clear"}, {31'b0, clr_a}, 32'd0);
    check({tag, "_write"}, {31'b0, wr_a}, 32'd0);
    check({tag, "_instr"}, instr_a, 32'd0);
    check({tag, "_count"}, {25'b0, cnt_a}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy_a}, 32'd0);
    check({tag, "_done"}, {31'b0, done_a}, 32'd0);
    check({tag, "_error"}, {31'b0, err_a}, 32'd0);
    check({tag, "_state"}, {29'b0, st_a}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ld_a = 1'b0; vld_a = 1'b0; dat_a = 8'h00; full_a = 1'b0;
    ld_b = 1'b0; vld_b = 1'b0; dat_b = 8'h00; full_b = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero_a("rst_a");
    check("rst_b_busy", {31'b0, busy_b}, 32'd0);
    check("rst_b_error", {31'b0, err_b}, 32'd0);
    rst_n = 1'b1;
    tick_a(1'b0, 1'b0, 8'h00);

    // Bytes before any load request are ignored.
    send_word_a(32'h01020304);
    check("idle_busy", {31'b0, busy_a}, 32'd0);
    check("idle_count", {25'b0, cnt_a}, 32'd0);

    // Single word.
    tick_a(1'b1, 1'b0, 8'h00);
    check("sw_clear", {31'b0, clr_a}, 32'd1);
    check("sw_busy_clear", {31'b0, busy_a}, 32'd1);
    check("sw_count0", {25'b0, cnt_a}, 32'd0);
    tick_a(1'b0, 1'b0, 8'h00);
    check("sw_clear_gone", {31'b0, clr_a}, 32'd0);
    check("sw_state_rx", {29'b0, st_a}, 32'd2);
    exp_q_a.push_back(32'h12345678);
    send_word_a(32'h12345678);
    check("sw_write", {31'b0, wr_a}, 32'd1);
    check("sw_instr", instr_a, 32'h12345678);
    check("sw_count1", {25'b0, cnt_a}, 32'd1);
    tick_a(1'b0, 1'b0, 8'h00);
    check("sw_write_low", {31'b0, wr_a}, 32'd0);
    check("sw_instr_hold", instr_a, 32'h12345678);

    // Program with halt, all bytes back-to-back.
    tick_a(1'b1, 1'b0, 8'h00);
    tick_a(1'b0, 1'b0, 8'h00);
    exp_q_a.push_back(32'hA1B2C3D4);
    exp_q_a.push_back(32'h00000000);
    exp_q_a.push_back(32'h7FFFFFFF);
    exp_q_a.push_back(32'hFFFFFFFF);
    send_word_a(32'hA1B2C3D4);
    send_word_a(32'h00000000);
    send_word_a(32'h7FFFFFFF);
    send_word_a(32'hFFFFFFFF);
    check("halt_write", {31'b0, wr_a}, 32'd1);
    check("halt_instr", instr_a, 32'hFFFFFFFF);
    check("halt_done", {31'b0, done_a}, 32'd1);
    check("halt_busy", {31'b0, busy_a}, 32'd0);
    check("halt_count", {25'b0, cnt_a}, 32'd4);
    check("halt_state", {29'b0, st_a}, 32'd3);
    send_word_a(32'h55555555);
    check("halt_count_hold", {25'b0, cnt_a}, 32'd4);
    check("halt_done_sticky", {31'b0, done_a}, 32'd1);
    check("halt_instr_hold", instr_a, 32'hFFFFFFFF);

    // Restart after DONE; a byte during CLEAR is dropped.
    tick_a(1'b1, 1'b0, 8'h00);
    check("rs_done_clr", {31'b0, done_a}, 32'd0);
    check("rs_clear", {31'b0, clr_a}, 32'd1);
    check("rs_count0", {25'b0, cnt_a}, 32'd0);
    tick_a(1'b0, 1'b1, 8'hAA);
    exp_q_a.push_back(32'h44332211);
    send_word_a(32'h44332211);
    check("rs_instr", instr_a, 32'h44332211);
    check("rs_count1", {25'b0, cnt_a}, 32'd1);

    // Abort mid-word; load_start beats a simultaneous byte.
    tick_a(1'b0, 1'b1, 8'h11);
    tick_a(1'b0, 1'b1, 8'h22);
    tick_a(1'b1, 1'b1, 8'h99);
    check("ab_clear", {31'b0, clr_a}, 32'd1);
    check("ab_count0", {25'b0, cnt_a}, 32'd0);
    tick_a(1'b0, 1'b0, 8'h00);
    exp_q_a.push_back(32'hDDCCBBAA);
    send_word_a(32'hDDCCBBAA);
    check("ab_instr", instr_a, 32'hDDCCBBAA);
    check("ab_count1", {25'b0, cnt_a}, 32'd1);

    // Asynchronous reset while a write pulse is on the outputs.
    exp_q_a.push_back(32'h0BADF00D);
    send_word_a(32'h0BADF00D);
    check("ar_pre_write", {31'b0, wr_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero_a("ar");
    @(negedge clk);
    rst_n = 1'b1;
    tick_a(1'b0, 1'b0, 8'h00);
    send_word_a(32'hCAFEBABE);
    check("ar_ignored_busy", {31'b0, busy_a}, 32'd0);
    check("ar_ignored_count", {25'b0, cnt_a}, 32'd0);

    // Memory full on the two-word instance.
    tick_b(1'b1, 1'b0, 8'h00);
    tick_b(1'b0, 1'b0, 8'h00);
    exp_q_b.push_back(32'h11111111);
    exp_q_b.push_back(32'h22222222);
    send_word_b(32'h11111111);
    send_word_b(32'h22222222);
    check("full_count2", {30'b0, cnt_b}, 32'd2);
    full_b = 1'b1;
    send_word_b(32'h33333333);
    check("full_write", {31'b0, wr_b}, 32'd0);
    check("full_error", {31'b0, err_b}, 32'd1);
    check("full_instr", instr_b, 32'h22222222);
    check("full_count", {30'b0, cnt_b}, 32'd2);
    check("full_busy", {31'b0, busy_b}, 32'd0);
    check("full_state", {29'b0, st_b}, 32'd4);
    tick_b(1'b0, 1'b0, 8'h00);
    check("full_error_sticky", {31'b0, err_b}, 32'd1);

    check("exp_q_a_left", exp_q_a.size(), 32'd0);
    check("exp_q_b_left", exp_q_b.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Program loader for the MIPS instruction memory in the `_if` stage. It receives a byte stream from the debug UART receiver and assembles it into 32-bit instruction words. Each complete word is driven onto the `_if` write port (`i_write_mem`, `i_instruction`, `i_clear_mem`). A load ends on the halt word `0xFFFFFFFF` or on a memory-full error. The block sits between the UART RX and `_if` in the debug unit.

## Interface
- `WORD_SIZE_IN_BYTES`, default 4: bytes per instruction word.
- `BYTE_BITS`, default 8: width of one UART byte.
- `MEM_SIZE_IN_WORDS`, default 64: sizes the word counter; must match `_if`.
- `i_clk` input, 1 bit: single clock; all state changes on its rising edge.
- `i_reset` input, 1 bit: reset, asynchronous and active-low.
- `i_load_start` input, 1 bit: single-cycle request to begin a new load.
- `i_rx_data` input, `BYTE_BITS` bits: received byte.
- `i_rx_valid` input, 1 bit: one-cycle strobe; `i_rx_data` is valid in that cycle.
- `i_full_mem` input, 1 bit: `o_full_mem` from `_if`.
- `o_clear_mem` output, 1 bit: to `_if` `i_clear_mem`; one-cycle pulse.
- `o_write_mem` output, 1 bit: to `_if` `i_write_mem`; one-cycle pulse per word.
- `o_instruction` output, `WORD_SIZE_IN_BYTES*BYTE_BITS` bits: to `_if` `i_instruction`.
- `o_word_count` output, `$clog2(MEM_SIZE_IN_WORDS+1)` bits: number of words written in the current load, halt word included.
- `o_busy` output, 1 bit: high in CLEAR and RECEIVE.
- `o_done` output, 1 bit: sticky; the halt word has been written.
- `o_error` output, 1 bit: sticky; a word was completed while memory was full.

## Operation
- States: IDLE, CLEAR, RECEIVE, DONE, ERROR. Reset enters IDLE.
- IDLE, DONE, ERROR: `i_rx_valid` is ignored. `i_load_start` moves to CLEAR.
- CLEAR: lasts exactly one cycle, with `o_clear_mem`=1. On entry it zeroes `o_word_count` and the byte index and clears `o_done`/`o_error`. Always moves to RECEIVE. Bytes arriving in CLEAR are dropped.
- RECEIVE, byte assembly: each accepted byte goes to shift register lane = byte index. Lane 0 is bits [7:0] (little-endian). Byte index counts 0..`WORD_SIZE_IN_BYTES`-1.
- RECEIVE, byte index below last: store the byte and increment the index.
- RECEIVE, last byte accepted, `i_full_mem`=1: no write; move to ERROR with `o_error`=1.
- RECEIVE, last byte accepted, `i_full_mem`=0: load `o_instruction` with the full word, pulse `o_write_mem`, increment `o_word_count`, reset the index to 0.
- RECEIVE, completed word equals all ones: the word is still written, then move to DONE with `o_done`=1.
- `i_load_start` in RECEIVE aborts the load and restarts at CLEAR. Partial bytes are discarded.
- If `i_load_start` and `i_rx_valid` arrive in the same cycle, `i_load_start` wins and the byte is dropped.
- `o_word_count` saturates at `MEM_SIZE_IN_WORDS`. It cannot exceed this because of the full check.

## Timing
- Reset values: `o_clear_mem`=0, `o_write_mem`=0, `o_instruction`=0, `o_word_count`=0, `o_busy`=0, `o_done`=0, `o_error`=0, state IDLE, byte index 0.
- All outputs are registered.
- `i_load_start` sampled at edge N: `o_clear_mem`=1 and `o_busy`=1 for the cycle after edge N. From edge N+1 the block is in RECEIVE.
- Last byte sampled at edge M: for the cycle after edge M, `o_write_mem`=1, `o_instruction` holds the new word, and `o_word_count` is already incremented. `o_write_mem` returns to 0 at edge M+1.
- Latency from the last byte strobe to the write pulse is one cycle.
- A new byte at edge M+1 is accepted normally as lane 0 of the next word. Back-to-back `i_rx_valid` every cycle is supported.
- Halt: `o_done` and the `o_write_mem` pulse rise in the same cycle; `o_busy` falls in that cycle.
- Full: `o_error` rises the cycle after the last byte, `o_write_mem` stays 0, and `o_instruction` keeps its previous value.
- `o_instruction` holds its value between writes.
- An asynchronous reset mid-word clears all outputs immediately. No write pulse is emitted.

## Test plan
- **Reset:** hold `i_reset`=0 mid-operation -> all outputs 0 at once; after release, bytes are ignored until `i_load_start`.
- **Single word:** `i_load_start`, then bytes 0x78, 0x56, 0x34, 0x12 -> exactly one `o_clear_mem` pulse; one `o_write_mem` pulse with `o_instruction`=0x12345678 one cycle after the 4th byte; `o_word_count`=1.
- **Program with halt:** three words, then 0xFF×4 sent on back-to-back cycles -> four write pulses; last `o_instruction`=0xFFFFFFFF; `o_done`=1; `o_word_count`=4; further bytes ignored.
- **Full memory:** with `MEM_SIZE_IN_WORDS`=2, send 3 non-halt words with `i_full_mem` raised after the 2nd write -> 2 write pulses, `o_error`=1, no 3rd pulse, `o_instruction` still word 2.
- **Abort:** send 2 bytes, then `i_load_start` in the same cycle as a 3rd byte -> CLEAR pulse; the next 4 bytes form the first word, not a mix with the old bytes; `o_word_count` restarts at 0.
- **Restart after DONE:** `i_load_start` -> `o_done`=0, `o_clear_mem` pulse, normal load proceeds.
